// File: rtl/lutram_mrp_if.sv
// Bus bundle for lutram_mrp: byte-strobed write port, clear request, busy flag
// and NUM_RPORTS independent read ports.
interface lutram_mrp_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_RPORTS = 2
);
  logic                                  en;
  logic                                  clear;
  logic                                  busy;
  logic [ADDR_WIDTH-1:0]                 waddr;
  logic [3:0]                            strobe;
  logic [31:0]                           wdata;
  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0] raddr;
  logic [NUM_RPORTS-1:0][31:0]           rdata;

  modport master (
    output en, clear, waddr, strobe, wdata, raddr,
    input  busy, rdata
  );

  modport slave (
    input  en, clear, waddr, strobe, wdata, raddr,
    output busy, rdata
  );
endinterface

// File: rtl/lutram_mrp.sv
// Multi-read-port LUTRAM with byte strobes, selectable read latency, optional
// write-first forwarding and a hardware clear sweep after reset or on request.
module lutram_mrp #(
  parameter int unsigned NUM_BYTES    = 64,
  parameter int unsigned NUM_RPORTS   = 2,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned BYPASS       = 1
) (
  input logic         clk,
  input logic         resetn,
  lutram_mrp_if.slave bus
);
  localparam int unsigned NUM_WORDS  = NUM_BYTES / 4;
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_WORDS);
  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned DATA_WIDTH = 32;

  if (!(NUM_BYTES == 16 || NUM_BYTES == 32 || NUM_BYTES == 64)) begin : g_bad_bytes
    $error("lutram_mrp: NUM_BYTES must be 16, 32 or 64");
  end
  if (NUM_RPORTS < 1 || NUM_RPORTS > 4) begin : g_bad_rports
    $error("lutram_mrp: NUM_RPORTS must be 1..4");
  end
  if (READ_LATENCY > 1) begin : g_bad_latency
    $error("lutram_mrp: READ_LATENCY must be 0 or 1");
  end

  typedef enum logic [1:0] {
    ST_SWEEP = 2'd0,
    ST_READY = 2'd1
  } state_e;

  state_e                                state_q, state_d;
  logic [ADDR_WIDTH-1:0]                 cnt_q, cnt_d;
  logic                                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0]                 mem_q [NUM_WORDS];

  logic                                  wact_c;
  logic                                  sweep_we_c;
  logic [NUM_LANES-1:0]                  lane_we_c;
  logic [ADDR_WIDTH-1:0]                 mem_waddr_c;
  logic [DATA_WIDTH-1:0]                 mem_wdata_c;
  logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] rd_c;

  // Sweep/ready sequencing; clear always restarts the sweep at word 0.
  always_comb begin : next_state
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SWEEP: begin
        if (bus.clear) begin
          cnt_d = '0;
        end else if (cnt_q == ADDR_WIDTH'(NUM_WORDS - 1)) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        if (bus.clear) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_SWEEP;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_SWEEP);
  end

  always_ff @(posedge clk) begin : state_reg
    if (!resetn) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;

  // Single physical write port shared by the sweep and the external writer.
  always_comb begin : write_port
    wact_c      = (state_q == ST_READY) && bus.en && (|bus.strobe) && !bus.clear;
    sweep_we_c  = (state_q == ST_SWEEP);
    mem_waddr_c = sweep_we_c ? cnt_q : bus.waddr;
    mem_wdata_c = sweep_we_c ? '0 : bus.wdata;
    lane_we_c   = sweep_we_c ? '1 : (wact_c ? bus.strobe : '0);
  end

  // Array is deliberately not reset; the sweep provides the known contents.
  always_ff @(posedge clk) begin : mem_write
    if (resetn) begin
      for (int j = 0; j < NUM_LANES; j++) begin
        if (lane_we_c[j]) begin
          mem_q[mem_waddr_c][8*j +: 8] <= mem_wdata_c[8*j +: 8];
        end
      end
    end
  end

  // Latency-0 view: stored word, optional per-lane forwarding, forced zero while busy.
  always_comb begin : read_ports
    for (int i = 0; i < NUM_RPORTS; i++) begin
      rd_c[i] = mem_q[bus.raddr[i]];
      for (int j = 0; j < NUM_LANES; j++) begin
        if ((BYPASS != 0) && wact_c && (bus.raddr[i] == bus.waddr) && bus.strobe[j]) begin
          rd_c[i][8*j +: 8] = bus.wdata[8*j +: 8];
        end
      end
      if (busy_q) begin
        rd_c[i] = '0;
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_reg_read
    logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;

    assign rdata_d = rd_c;

    always_ff @(posedge clk) begin : rdata_reg
      if (!resetn) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign bus.rdata = rdata_q;
  end else begin : g_comb_read
    assign bus.rdata = rd_c;
  end
endmodule

// File: tb/tb_lutram_mrp.sv
// Directed bench for lutram_mrp: four 64-byte 4-port variants (latency x bypass)
// plus a 16-byte single-port variant, all driven by the same stimulus.
module tb_lutram_mrp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn;
  logic            en;
  logic            clear;
  logic [3:0]      waddr;
  logic [3:0]      strobe;
  logic [31:0]     wdata;
  logic [3:0][3:0] raddr;

  int vectors     = 0;
  int miscompares = 0;

  // index 0: L0/B1, 1: L0/B0, 2: L1/B0, 3: L1/B1
  lutram_mrp_if #(.ADDR_WIDTH(4), .NUM_RPORTS(4)) if_a ();
  lutram_mrp_if #(.ADDR_WIDTH(4), .NUM_RPORTS(4)) if_b ();
  lutram_mrp_if #(.ADDR_WIDTH(4), .NUM_RPORTS(4)) if_c ();
  lutram_mrp_if #(.ADDR_WIDTH(4), .NUM_RPORTS(4)) if_d ();
  lutram_mrp_if #(.ADDR_WIDTH(2), .NUM_RPORTS(1)) if_e ();

  lutram_mrp #(.NUM_BYTES(64), .NUM_RPORTS(4), .READ_LATENCY(0), .BYPASS(1))
    u_a (.clk(clk), .resetn(resetn), .bus(if_a));
  lutram_mrp #(.NUM_BYTES(64), .NUM_RPORTS(4), .READ_LATENCY(0), .BYPASS(0))
    u_b (.clk(clk), .resetn(resetn), .bus(if_b));
  lutram_mrp #(.NUM_BYTES(64), .NUM_RPORTS(4), .READ_LATENCY(1), .BYPASS(0))
    u_c (.clk(clk), .resetn(resetn), .bus(if_c));
  lutram_mrp #(.NUM_BYTES(64), .NUM_RPORTS(4), .READ_LATENCY(1), .BYPASS(1))
    u_d (.clk(clk), .resetn(resetn), .bus(if_d));
  lutram_mrp #(.NUM_BYTES(16), .NUM_RPORTS(1), .READ_LATENCY(0), .BYPASS(1))
    u_e (.clk(clk), .resetn(resetn), .bus(if_e));

  assign if_a.en = en;  assign if_a.clear = clear;  assign if_a.waddr = waddr;
  assign if_a.strobe = strobe;  assign if_a.wdata = wdata;  assign if_a.raddr = raddr;
  assign if_b.en = en;  assign if_b.clear = clear;  assign if_b.waddr = waddr;
  assign if_b.strobe = strobe;  assign if_b.wdata = wdata;  assign if_b.raddr = raddr;
  assign if_c.en = en;  assign if_c.clear = clear;  assign if_c.waddr = waddr;
  assign if_c.strobe = strobe;  assign if_c.wdata = wdata;  assign if_c.raddr = raddr;
  assign if_d.en = en;  assign if_d.clear = clear;  assign if_d.waddr = waddr;
  assign if_d.strobe = strobe;  assign if_d.wdata = wdata;  assign if_d.raddr = raddr;
  assign if_e.en = en;  assign if_e.clear = clear;  assign if_e.waddr = waddr[1:0];
  assign if_e.strobe = strobe;  assign if_e.wdata = wdata;  assign if_e.raddr = raddr[0][1:0];

  logic [3:0][31:0] rd [4];
  logic [3:0]       busy4;
  logic             busy_e;
  logic [31:0]      rd_e;

  assign rd[0]  = if_a.rdata;
  assign rd[1]  = if_b.rdata;
  assign rd[2]  = if_c.rdata;
  assign rd[3]  = if_d.rdata;
  assign busy4  = {if_d.busy, if_c.busy, if_b.busy, if_a.busy};
  assign busy_e = if_e.busy;
  assign rd_e   = if_e.rdata[0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en     = 1'b0;
    clear  = 1'b0;
    strobe = 4'h0;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    waddr  = a;
    wdata  = d;
    strobe = s;
    en     = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    int n64;
    int ne;
    n64 = 0;
    ne  = 0;
    idle();
    resetn = 1'b0;
    waddr  = 4'd0;
    wdata  = 32'h0;
    raddr  = {4{4'd3}};
    tick();
    tick();
    for (int d = 2; d < 4; d++) begin
      for (int p = 0; p < 4; p++) begin
        vectors++;
        if (rd[d][p] !== 32'h0) begin
          miscompares++;
          $display("FAIL reset_rdata: dut%0d port%0d got %h expected %h", d, p, rd[d][p], 32'h0);
        end
      end
    end
    vectors++;
    if (busy4 !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_busy: got %b expected %b", busy4, 4'hF);
    end
    resetn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (busy4[0]) n64++;
      if (busy_e) ne++;
      if (k == 3) begin
        waddr  = 4'd3;
        wdata  = 32'h5A5A5A5A;
        strobe = 4'hF;
        en     = 1'b1;
        #1;
        vectors++;
        if (rd[0][0] !== 32'h0) begin
          miscompares++;
          $display("FAIL busy_read_zero: got %h expected %h", rd[0][0], 32'h0);
        end
      end else begin
        idle();
      end
      tick();
    end
    idle();
    vectors++;
    if (n64 !== 16) begin
      miscompares++;
      $display("FAIL reset_busy_len64: got %0d expected %0d", n64, 16);
    end
    vectors++;
    if (ne !== 4) begin
      miscompares++;
      $display("FAIL reset_busy_len16: got %0d expected %0d", ne, 4);
    end
  endtask

  task automatic test_array_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      raddr = {4{4'(a)}};
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 4; p++) begin
          vectors++;
          if (rd[d][p] !== 32'h0) begin
            miscompares++;
            $display("FAIL %s_zero: dut%0d port%0d addr%0d got %h expected %h",
                     tag, d, p, a, rd[d][p], 32'h0);
          end
        end
      end
      if (a < 4) begin
        vectors++;
        if (rd_e !== 32'h0) begin
          miscompares++;
          $display("FAIL %s_zero16: addr%0d got %h expected %h", tag, a, rd_e, 32'h0);
        end
      end
      tick();
      for (int d = 2; d < 4; d++) begin
        for (int p = 0; p < 4; p++) begin
          vectors++;
          if (rd[d][p] !== 32'h0) begin
            miscompares++;
            $display("FAIL %s_zero: dut%0d port%0d addr%0d got %h expected %h",
                     tag, d, p, a, rd[d][p], 32'h0);
          end
        end
      end
    end
  endtask

  task automatic test_strobes();
    write_word(4'd5, 32'hDEADBEEF, 4'b1111);
    write_word(4'd5, 32'h11223344, 4'b0101);
    raddr = {4{4'd5}};
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 4; p++) begin
        vectors++;
        if (rd[d][p] !== 32'hDE22BE44) begin
          miscompares++;
          $display("FAIL strobes: dut%0d port%0d got %h expected %h", d, p, rd[d][p], 32'hDE22BE44);
        end
      end
    end
    tick();
    for (int d = 2; d < 4; d++) begin
      for (int p = 0; p < 4; p++) begin
        vectors++;
        if (rd[d][p] !== 32'hDE22BE44) begin
          miscompares++;
          $display("FAIL strobes: dut%0d port%0d got %h expected %h", d, p, rd[d][p], 32'hDE22BE44);
        end
      end
    end
  endtask

  task automatic test_forward();
    write_word(4'd2, 32'hAAAAAAAA, 4'b1111);
    raddr  = {4'd0, 4'd0, 4'd0, 4'd2};
    waddr  = 4'd2;
    wdata  = 32'h12345678;
    strobe = 4'b0011;
    en     = 1'b1;
    #1;
    vectors++;
    if (rd[0][0] !== 32'hAAAA5678) begin
      miscompares++;
      $display("FAIL fwd_bypass1_lat0: got %h expected %h", rd[0][0], 32'hAAAA5678);
    end
    vectors++;
    if (rd[1][0] !== 32'hAAAAAAAA) begin
      miscompares++;
      $display("FAIL fwd_bypass0_lat0: got %h expected %h", rd[1][0], 32'hAAAAAAAA);
    end
    tick();
    idle();
    vectors++;
    if (rd[2][0] !== 32'hAAAAAAAA) begin
      miscompares++;
      $display("FAIL fwd_bypass0_lat1_first: got %h expected %h", rd[2][0], 32'hAAAAAAAA);
    end
    vectors++;
    if (rd[3][0] !== 32'hAAAA5678) begin
      miscompares++;
      $display("FAIL fwd_bypass1_lat1_first: got %h expected %h", rd[3][0], 32'hAAAA5678);
    end
    vectors++;
    if (rd[1][0] !== 32'hAAAA5678) begin
      miscompares++;
      $display("FAIL fwd_stored_lat0: got %h expected %h", rd[1][0], 32'hAAAA5678);
    end
    tick();
    vectors++;
    if (rd[2][0] !== 32'hAAAA5678) begin
      miscompares++;
      $display("FAIL fwd_bypass0_lat1_second: got %h expected %h", rd[2][0], 32'hAAAA5678);
    end
  endtask

  task automatic test_multiport();
    logic [31:0] exp_v [4];
    write_word(4'd0,  32'hA0A0A0A0, 4'hF);
    write_word(4'd1,  32'hB1B1B1B1, 4'hF);
    write_word(4'd15, 32'hCAFE000F, 4'hF);
    exp_v[0] = 32'hA0A0A0A0;
    exp_v[1] = 32'hB1B1B1B1;
    exp_v[2] = 32'hB1B1B1B1;
    exp_v[3] = 32'hCAFE000F;
    raddr = {4'd15, 4'd1, 4'd1, 4'd0};
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 4; p++) begin
        vectors++;
        if (rd[d][p] !== exp_v[p]) begin
          miscompares++;
          $display("FAIL multiport: dut%0d port%0d got %h expected %h", d, p, rd[d][p], exp_v[p]);
        end
      end
    end
    tick();
    for (int d = 2; d < 4; d++) begin
      for (int p = 0; p < 4; p++) begin
        vectors++;
        if (rd[d][p] !== exp_v[p]) begin
          miscompares++;
          $display("FAIL multiport: dut%0d port%0d got %h expected %h", d, p, rd[d][p], exp_v[p]);
        end
      end
    end
  endtask

  task automatic test_clear();
    int n64;
    int nreg;
    int ne;
    n64  = 0;
    nreg = 0;
    ne   = 0;
    for (int a = 0; a < 16; a++) write_word(4'(a), 32'hFFFFFFFF, 4'hF);
    raddr = {4{4'd7}};
    #1;
    vectors++;
    if (rd[0][0] !== 32'hFFFFFFFF) begin
      miscompares++;
      $display("FAIL clear_prefill: got %h expected %h", rd[0][0], 32'hFFFFFFFF);
    end
    waddr  = 4'd0;
    wdata  = 32'h1;
    strobe = 4'hF;
    en     = 1'b1;
    clear  = 1'b1;
    tick();
    idle();
    for (int k = 0; k < 40; k++) begin
      if (busy4[0]) n64++;
      if (busy4[2]) nreg++;
      if (busy_e) ne++;
      clear = (k == 5);
      if (k == 8) begin
        vectors++;
        if (rd[0][0] !== 32'h0) begin
          miscompares++;
          $display("FAIL clear_busy_lat0: got %h expected %h", rd[0][0], 32'h0);
        end
        vectors++;
        if (rd[2][0] !== 32'h0) begin
          miscompares++;
          $display("FAIL clear_busy_lat1: got %h expected %h", rd[2][0], 32'h0);
        end
      end
      tick();
    end
    idle();
    vectors++;
    if (n64 !== 22) begin
      miscompares++;
      $display("FAIL clear_busy_len64: got %0d expected %0d", n64, 22);
    end
    vectors++;
    if (nreg !== 22) begin
      miscompares++;
      $display("FAIL clear_busy_len64_lat1: got %0d expected %0d", nreg, 22);
    end
    vectors++;
    if (ne !== 8) begin
      miscompares++;
      $display("FAIL clear_busy_len16: got %0d expected %0d", ne, 8);
    end
    test_array_zero("clear");
  endtask

  initial begin
    test_reset();
    test_array_zero("reset");
    test_strobes();
    test_forward();
    test_multiport();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
